// File: rtl/ysyx_23060077_riscv_ctrl_if.sv
// Memory-side handshake bundle between the core sequencer (master) and the
// IFU/LSU (slave).
interface ysyx_23060077_riscv_ctrl_if;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic        ifu_rsp_valid;
   logic        ifu_rsp_err;
   logic [31:0] ifu_rsp_inst;
   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic        lsu_rsp_valid;
   logic        lsu_rsp_err;

   modport master (
      output ifu_req_valid,
      input  ifu_req_ready,
      input  ifu_rsp_valid,
      input  ifu_rsp_err,
      input  ifu_rsp_inst,
      output lsu_req_valid,
      input  lsu_req_ready,
      input  lsu_rsp_valid,
      input  lsu_rsp_err
   );

   modport slave (
      input  ifu_req_valid,
      output ifu_req_ready,
      output ifu_rsp_valid,
      output ifu_rsp_err,
      output ifu_rsp_inst,
      input  lsu_req_valid,
      output lsu_req_ready,
      output lsu_rsp_valid,
      output lsu_rsp_err
   );
endinterface

// File: rtl/ysyx_23060077_riscv_ctrl.sv
// Multi-cycle instruction sequencer: owns PC/IR, handshakes with IFU and LSU,
// and halts the core on the first trap.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE (0)    | halt=0: post-reset, launches first fetch; halt=1: HALT
// FETCH_REQ   | ifu_req_valid high, pc stable, waiting for ifu_req_ready
// FETCH_WAIT  | waiting for ifu_rsp_valid, loads inst
// DECODE      | samples dec_* flags, illegal/ebreak traps
// EXEC        | computes next pc, misaligned-target trap
// MEM_REQ     | lsu_req_valid high, waiting for lsu_req_ready
// MEM_WAIT    | waiting for lsu_rsp_valid
// WB          | rd_wen strobe, pc/instret commit
module ysyx_23060077_riscv_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic                              clk,
   input  logic                              rst_n,
   ysyx_23060077_riscv_ctrl_if.master        bus,
   output logic [31:0]                       inst,
   input  logic                              dec_lsu_en,
   input  logic                              dec_rd_wen,
   input  logic                              dec_ebreak,
   input  logic                              dec_illegal,
   input  logic                              exu_redirect,
   input  logic [31:0]                       exu_next_pc,
   output logic [31:0]                       pc,
   output logic                              rd_wen,
   output logic [31:0]                       instret,
   output logic                              halt,
   output logic [2:0]                        trap_cause
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FETCH_REQ  = 3'd1,
      S_FETCH_WAIT = 3'd2,
      S_DECODE     = 3'd3,
      S_EXEC       = 3'd4,
      S_MEM_REQ    = 3'd5,
      S_MEM_WAIT   = 3'd6,
      S_WB         = 3'd7
   } state_t;

   localparam logic [2:0] C_NONE      = 3'd0;
   localparam logic [2:0] C_EBREAK    = 3'd1;
   localparam logic [2:0] C_ILLEGAL   = 3'd2;
   localparam logic [2:0] C_FETCH_ERR = 3'd3;
   localparam logic [2:0] C_LSU_ERR   = 3'd4;
   localparam logic [2:0] C_TIMEOUT   = 3'd5;
   localparam logic [2:0] C_MISALIGN  = 3'd6;

   // The counter is 0 in the first cycle of a wait state, so the TIMEOUT-th
   // cycle is the one where it equals TIMEOUT-1. A 16-bit saturating count
   // can never reach limits above 65536, which therefore disable the check.
   localparam bit          TO_EN    = (TIMEOUT != 0) && (TIMEOUT <= 65536);
   localparam int unsigned TO_LIM_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [15:0] TO_LIM   = TO_LIM_I[15:0];

   state_t      state_q;
   state_t      state_nx;
   logic        trap_now;
   logic [2:0]  cause_nx;
   logic        rel_q;
   logic [15:0] wait_cnt;
   logic        in_hs;
   logic        timeout_hit;
   logic        lsu_en_q;
   logic        rd_wen_q;
   logic [31:0] next_pc_q;
   logic [31:0] pc_inc;
   logic [31:0] npc_calc;

   assign pc_inc      = pc + 32'd4;
   assign npc_calc    = exu_redirect ? exu_next_pc : pc_inc;
   assign in_hs       = (state_q == S_FETCH_REQ) || (state_q == S_FETCH_WAIT) ||
                        (state_q == S_MEM_REQ)   || (state_q == S_MEM_WAIT);
   assign timeout_hit = TO_EN && in_hs && (wait_cnt >= TO_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   always_comb begin
      state_nx = state_q;
      trap_now = 1'b0;
      cause_nx = C_NONE;
      case (state_q)
         S_IDLE: begin
            // rel_q holds IDLE for one full cycle after reset release
            if (!halt && rel_q) state_nx = S_FETCH_REQ;
         end
         S_FETCH_REQ: begin
            if (bus.ifu_req_ready) begin
               state_nx = S_FETCH_WAIT;
            end else if (timeout_hit) begin
               trap_now = 1'b1;
               cause_nx = C_TIMEOUT;
            end
         end
         S_FETCH_WAIT: begin
            if (bus.ifu_rsp_valid) begin
               if (bus.ifu_rsp_err) begin
                  trap_now = 1'b1;
                  cause_nx = C_FETCH_ERR;
               end else begin
                  state_nx = S_DECODE;
               end
            end else if (timeout_hit) begin
               trap_now = 1'b1;
               cause_nx = C_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (dec_illegal) begin
               trap_now = 1'b1;
               cause_nx = C_ILLEGAL;
            end else if (dec_ebreak) begin
               trap_now = 1'b1;
               cause_nx = C_EBREAK;
            end else begin
               state_nx = S_EXEC;
            end
         end
         S_EXEC: begin
            if (npc_calc[1:0] != 2'b00) begin
               trap_now = 1'b1;
               cause_nx = C_MISALIGN;
            end else if (lsu_en_q) begin
               state_nx = S_MEM_REQ;
            end else begin
               state_nx = S_WB;
            end
         end
         S_MEM_REQ: begin
            if (bus.lsu_req_ready) begin
               state_nx = S_MEM_WAIT;
            end else if (timeout_hit) begin
               trap_now = 1'b1;
               cause_nx = C_TIMEOUT;
            end
         end
         S_MEM_WAIT: begin
            if (bus.lsu_rsp_valid) begin
               if (bus.lsu_rsp_err) begin
                  trap_now = 1'b1;
                  cause_nx = C_LSU_ERR;
               end else begin
                  state_nx = S_WB;
               end
            end else if (timeout_hit) begin
               trap_now = 1'b1;
               cause_nx = C_TIMEOUT;
            end
         end
         S_WB: begin
            state_nx = S_FETCH_REQ;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
      // HALT shares the IDLE code; the sticky halt flag keeps it there
      if (trap_now) state_nx = S_IDLE;
   end

   always_comb begin
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      rd_wen            = 1'b0;
      case (state_q)
         S_FETCH_REQ: bus.ifu_req_valid = 1'b1;
         S_MEM_REQ:   bus.lsu_req_valid = 1'b1;
         S_WB:        rd_wen            = rd_wen_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rel_q      <= 1'b0;
         pc         <= RESET_PC;
         inst       <= 32'd0;
         instret    <= 32'd0;
         halt       <= 1'b0;
         trap_cause <= C_NONE;
         wait_cnt   <= 16'd0;
         lsu_en_q   <= 1'b0;
         rd_wen_q   <= 1'b0;
         next_pc_q  <= 32'd0;
      end else begin
         rel_q <= 1'b1;

         if (state_nx != state_q) begin
            wait_cnt <= 16'd0;
         end else if (in_hs && (wait_cnt != 16'hFFFF)) begin
            wait_cnt <= wait_cnt + 16'd1;
         end

         if ((state_q == S_FETCH_WAIT) && bus.ifu_rsp_valid && !bus.ifu_rsp_err) begin
            inst <= bus.ifu_rsp_inst;
         end

         if (state_q == S_DECODE) begin
            lsu_en_q <= dec_lsu_en;
            rd_wen_q <= dec_rd_wen;
         end

         if (state_q == S_EXEC) begin
            next_pc_q <= npc_calc;
         end

         if (state_q == S_WB) begin
            pc      <= next_pc_q;
            instret <= instret + 32'd1;
         end

         if (trap_now) begin
            halt       <= 1'b1;
            trap_cause <= cause_nx;
         end
      end
   end

endmodule

// File: doc/ysyx_23060077_riscv_ctrl.md
# ysyx_23060077_riscv_ctrl

Multi-cycle sequencer for the ysyx_23060077 core. It owns the PC and instruction register. It steps each instruction through fetch, decode, execute, optional memory access and writeback, handshaking with the IFU and LSU. It also detects trap conditions and halts the core, and sits between the memory-side units and the decode/execute datapath.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- TIMEOUT, 1024, max cycles in any handshake state before timeout trap; 0 disables
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- ifu_req_valid  out  1  fetch request at address pc
- ifu_req_ready  in  1  IFU accepts request
- ifu_rsp_valid  in  1  fetch data valid
- ifu_rsp_err  in  1  fetch bus error, qualified by ifu_rsp_valid
- ifu_rsp_inst  in  32  fetched instruction
- inst  out  32  instruction register, drives the decoder
- dec_lsu_en  in  1  decoded instruction is load/store
- dec_rd_wen  in  1  decoded instruction writes rd
- dec_ebreak  in  1  decoded EBREAK
- dec_illegal  in  1  decoder found no match
- exu_redirect  in  1  branch taken or jump, valid in EXEC
- exu_next_pc  in  32  redirect target, valid in EXEC
- lsu_req_valid  out  1  memory request
- lsu_req_ready  in  1  LSU accepts request
- lsu_rsp_valid  in  1  LSU completion
- lsu_rsp_err  in  1  LSU error, qualified by lsu_rsp_valid
- pc  out  32  current PC
- rd_wen  out  1  register-file write strobe, one-cycle pulse in WB
- instret  out  32  retired-instruction count
- halt  out  1  sticky halt
- trap_cause  out  3  0 none, 1 ebreak, 2 illegal, 3 fetch err, 4 lsu err, 5 timeout, 6 misaligned target

## Operation
- States: IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT (3-bit encoding).
- IDLE: entered on reset; all outputs 0 except pc=RESET_PC. Moves to FETCH_REQ next cycle unconditionally.
- FETCH_REQ: ifu_req_valid=1.
  - Holds until ifu_req_ready, then goes to FETCH_WAIT.
- FETCH_WAIT: waits for ifu_rsp_valid.
  - With ifu_rsp_err=1: HALT, cause 3; err takes priority over data.
  - Otherwise: inst<=ifu_rsp_inst, go to DECODE.
- DECODE: one cycle; samples dec_* inputs.
  - dec_illegal: HALT, cause 2.
  - Else dec_ebreak: HALT, cause 1.
  - Illegal has priority over ebreak.
  - Otherwise: latch dec_lsu_en and dec_rd_wen, go to EXEC.
- EXEC: one cycle; latches next_pc = exu_redirect ? exu_next_pc : pc+4.
  - next_pc[1:0]≠0: HALT, cause 6.
  - Else, latched lsu_en: go to MEM_REQ.
  - Else: go to WB.
- MEM_REQ: lsu_req_valid=1 until lsu_req_ready, then go to MEM_WAIT.
- MEM_WAIT: waits for lsu_rsp_valid.
  - lsu_rsp_err: HALT, cause 4.
  - Otherwise: go to WB.
- WB: one cycle.
  - rd_wen = latched rd_wen.
  - pc<=next_pc; instret<=instret+1 (wraps 32'hFFFF_FFFF→0).
  - Go to FETCH_REQ.
- HALT: terminal until reset.
  - halt=1; trap_cause holds the first cause.
  - req/rd_wen outputs 0; pc and instret frozen.
- Timeout: wait counter (16 bit, saturating) clears on every state change and increments each cycle spent in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT. When it reaches TIMEOUT≠0 and no handshake completes that cycle: HALT, cause 5.
- Responses (ifu_rsp_valid, lsu_rsp_valid) outside their WAIT state are ignored.
- pc+4 wraps modulo 2^32.

## Timing
- Reset: asynchronous assert. All regs clear immediately: state=IDLE, pc=RESET_PC, inst=0, instret=0, halt=0, trap_cause=0, counter=0. Mid-instruction reset abandons any outstanding IFU/LSU transaction.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Handshake: req_valid stays high, with pc stable, until the cycle req_ready=1. A request completes on the clock edge where valid&ready. The response is accepted no earlier than the following cycle.
- Minimum latency, zero-wait IFU (ready=1, rsp next cycle):
  - ALU instruction: FETCH_REQ→FETCH_WAIT→DECODE→EXEC→WB, 5 cycles.
  - Load/store with zero-wait LSU: 7 cycles.
- First ifu_req_valid rises the second rising edge after rst_n deasserts (after IDLE).
- halt and trap_cause update on the edge leaving the trapping state; they are visible the next cycle.

## Test plan
- Reset release, ready tied 1, rsp one cycle later, inst=ADDI, dec_rd_wen=1 -> ifu_req_valid at cycle 1 with pc=0x8000_0000; rd_wen pulse at cycle 5; pc=0x8000_0004, instret=1.
- Load with lsu_req_ready delayed 3 cycles, rsp 2 cycles later -> lsu_req_valid held 4 cycles; rd_wen one cycle after rsp; instret increments once.
- Branch with exu_redirect=1, exu_next_pc=0x8000_0100 -> next fetch at 0x8000_0100. Target 0x8000_0102 -> halt=1, cause 6, pc unchanged.
- dec_illegal=1 and dec_ebreak=1 in same DECODE -> cause 2. Later ifu/lsu responses ignored; outputs stay 0 until reset.
- ifu_req_ready held 0, TIMEOUT=8 -> halt, cause 5, after 8 cycles in FETCH_REQ. Repeat with ready at cycle 7 -> no trap.
- Assert rst_n=0 during MEM_WAIT, release -> state IDLE, pc=RESET_PC, instret=0, halt=0; stale lsu_rsp_valid during FETCH ignored.
